// File: rtl/wb_stream_writer_core.sv
// wb_stream_writer_core
//   Reads a buffer from memory through a Wishbone B3 burst master into a
//   first-word-fall-through FIFO and presents it as a valid/ready word stream.
//   An interrupt is raised once the whole buffer has been fetched and drained.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   wbm_*                Wishbone B3 read master (incrementing bursts)
//   stream_m_*           output word stream plus completion interrupt
//   wbs_*                Wishbone slave configuration port (1 wait state)
//
// Stream handshake: stream_m_data_o is valid whenever stream_m_valid_o is 1;
// a word is consumed on a rising edge where valid and ready are both 1.
// Ready while valid is 0 has no effect.
//
// Register map (byte offsets, only adr[3:2] decoded)
//   0x0 ENABLE      write bit0 = start (ignored while busy), bit1 = clear irq
//   0x4 START_ADDR  byte address of the buffer
//   0x8 BUF_SIZE    bytes, multiple of 4; 0 completes immediately
//   0xC BURST_SIZE  words per burst, 1..MAX_BURST_LEN
//
// Optional build macro
//   WB_STREAM_WRITER_READBACK_EN  when defined, wbs_dat_o returns register
//   contents (ENABLE reads {30'b0, irq, busy}); otherwise it is tied to 0.
module wb_stream_writer_core #(
  parameter int FIFO_AW       = 5,
  parameter int MAX_BURST_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic [31:0] stream_m_data_o,
  output logic        stream_m_valid_o,
  input  logic        stream_m_ready_i,
  output logic        stream_m_irq_o,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o
);

  localparam int          DEPTH   = 2 ** FIFO_AW;
  localparam int          CW      = FIFO_AW + 1;
  localparam int          BW      = $clog2(MAX_BURST_LEN + 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [31:0] MAX_W   = 32'(MAX_BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t state, state_next;

  logic [31:0] start_addr, buf_size, burst_size;
  logic        irq;
  logic [31:0] adr_q;
  logic [29:0] remaining;
  logic [BW-1:0] beats_left;
  logic        rty_hold;

  logic [31:0]      fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  logic        cfg_wr, start_req, clr_irq, beat_ack, push, pop, can_issue;
  logic [31:0] burst_lim, burst_words, free_slots;

  assign cfg_wr    = wbs_cyc_i & wbs_stb_i & wbs_ack_o & wbs_we_i;
  assign start_req = cfg_wr && (wbs_adr_i[3:2] == 2'd0) && wbs_dat_i[0] && (state == S_IDLE);
  assign clr_irq   = cfg_wr && (wbs_adr_i[3:2] == 2'd0) && wbs_dat_i[1];

  // Out-of-range burst sizes are clamped so a bad setting cannot overrun the FIFO.
  assign burst_lim   = (burst_size == 32'd0) ? 32'd1 :
                       (burst_size > MAX_W) ? MAX_W : burst_size;
  assign burst_words = ({2'b00, remaining} < burst_lim) ? {2'b00, remaining} : burst_lim;
  assign free_slots  = DEPTH_W - 32'(count);
  // Reserving the whole burst up front guarantees the FIFO never overflows.
  assign can_issue   = (remaining != 30'd0) && (free_slots >= burst_words);

  assign beat_ack = (state == S_BURST) && wbm_stb_o && wbm_ack_i;
  assign push     = beat_ack;
  assign pop      = stream_m_valid_o && stream_m_ready_i;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_cti_o  = 3'b000;
    case (state)
      S_IDLE:  if (start_req) state_next = S_WAIT;
      S_WAIT: begin
        // Completion waits for the consumer to drain the last word.
        if (remaining == 30'd0) begin
          if (count == '0) state_next = S_DONE;
        end else if (can_issue) begin
          state_next = S_BURST;
        end
      end
      S_BURST: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = !rty_hold;
        wbm_cti_o = (beats_left == BW'(1)) ? 3'b111 : 3'b010;
        if (wbm_err_i)                                state_next = S_DONE;
        else if (beat_ack && beats_left == BW'(1))    state_next = S_WAIT;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_ack_o  <= 1'b0;
      start_addr <= '0;
      buf_size   <= '0;
      burst_size <= '0;
      irq        <= 1'b0;
      adr_q      <= '0;
      remaining  <= '0;
      beats_left <= '0;
      rty_hold   <= 1'b0;
    end else begin
      wbs_ack_o <= wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
      if (cfg_wr) begin
        case (wbs_adr_i[3:2])
          2'd1:    start_addr <= wbs_dat_i;
          2'd2:    buf_size   <= wbs_dat_i;
          2'd3:    burst_size <= wbs_dat_i;
          default: ;
        endcase
      end
      if (state == S_DONE) irq <= 1'b1;
      else if (clr_irq)    irq <= 1'b0;
      if (start_req) begin
        adr_q     <= start_addr;
        remaining <= buf_size[31:2];
      end
      if (state == S_WAIT && state_next == S_BURST) beats_left <= burst_words[BW-1:0];
      // A retry response holds stb low for exactly one cycle before re-presenting the beat.
      rty_hold <= (state == S_BURST) && wbm_stb_o && wbm_rty_i && !wbm_ack_i && !wbm_err_i;
      if (beat_ack) begin
        adr_q      <= adr_q + 32'd4;
        remaining  <= remaining - 30'd1;
        beats_left <= beats_left - BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wbm_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign stream_m_valid_o = (count != '0);
  assign stream_m_data_o  = fifo_mem[rd_ptr];
  assign stream_m_irq_o   = irq;

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = 32'd0;
  assign wbm_sel_o = 4'hf;
  assign wbm_we_o  = 1'b0;
  assign wbm_bte_o = 2'b00;
  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;

`ifdef WB_STREAM_WRITER_READBACK_EN
  logic [31:0] rd_data;
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else if (wbs_cyc_i & wbs_stb_i & ~wbs_ack_o) begin
      case (wbs_adr_i[3:2])
        2'd0:    rd_data <= {30'd0, irq, (state != S_IDLE)};
        2'd1:    rd_data <= start_addr;
        2'd2:    rd_data <= buf_size;
        default: rd_data <= burst_size;
      endcase
    end
  end
  assign wbs_dat_o = rd_data;
`else
  assign wbs_dat_o = 32'd0;
`endif

  logic unused_bits;
  assign unused_bits = ^{wbs_sel_i, wbs_cti_i, wbs_bte_i, wbs_adr_i[31:4],
                         wbs_adr_i[1:0], buf_size[1:0]};

endmodule

// File: tb/tb_wb_stream_writer_core.sv
module tb_wb_stream_writer_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
  logic [31:0] stream_m_data_o;
  logic        stream_m_valid_o, stream_m_irq_o;
  logic        stream_m_ready_i = 1'b0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic [3:0]  wbs_sel_i = 4'hf;
  logic        wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
  logic [2:0]  wbs_cti_i = '0;
  logic [1:0]  wbs_bte_i = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, wbs_rty_o;

  always #5 clk = ~clk;

  wb_stream_writer_core dut (
    .clk(clk), .rst(rst),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
    .stream_m_ready_i(stream_m_ready_i), .stream_m_irq_o(stream_m_irq_o),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  logic [31:0] exp_q[$];
  logic [31:0] exp_adr_q[$];
  logic [2:0]  exp_cti_q[$];

  int acks = 0, pops = 0, bursts = 0;
  int err_at = -1, max_delay = 0, rty_pct = 0, ready_pct = 100, wait_cnt = 0;
  logic prev_cyc = 1'b0, last_final = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory slave: random wait states, optional retries, one optional error beat.
  always @(negedge clk) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    if (rst) wait_cnt = 0;
    else if (wbm_cyc_o && wbm_stb_o) begin
      if (wait_cnt > 0) wait_cnt--;
      else begin
        if (acks == err_at) wbm_err_i = 1'b1;
        else if (int'($urandom_range(99)) < rty_pct) wbm_rty_i = 1'b1;
        else begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = mem[wbm_adr_o[11:2]];
        end
        wait_cnt = int'($urandom_range(max_delay));
      end
    end
    stream_m_ready_i = (int'($urandom_range(99)) < ready_pct);
  end

  // Monitor / scoreboard: sampled late in the low phase, before the next rising edge.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      prev_cyc   = 1'b0;
      last_final = 1'b0;
    end else begin
      if (last_final) begin
        check("cyc_drop_after_last", wbm_cyc_o, 1'b0);
        last_final = 1'b0;
      end
      if (wbm_cyc_o && !prev_cyc) bursts++;
      prev_cyc = wbm_cyc_o;
      if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i)) begin
        if (exp_adr_q.size() == 0) check("unexpected_beat", 32'd1, 32'd0);
        else begin
          logic [31:0] a;
          logic [2:0]  c;
          a = exp_adr_q.pop_front();
          c = exp_cti_q.pop_front();
          check("beat_adr", wbm_adr_o, a);
          if (wbm_ack_i) check("beat_cti", {29'd0, wbm_cti_o}, {29'd0, c});
        end
        if (wbm_ack_i) begin
          acks++;
          if (acks - pops > 32) check("fifo_overflow", acks - pops, 32);
          if (wbm_cti_o == 3'b111) last_final = 1'b1;
        end
      end
      if (stream_m_valid_o && stream_m_ready_i) begin
        pops++;
        if (exp_q.size() == 0) check("unexpected_word", 32'd1, 32'd0);
        else check("stream_data", stream_m_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output logic [31:0] rdata);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wbs_ack_o) break;
    end
    rdata = wbs_dat_o;
    check("wbs_ack", wbs_ack_o, 1'b1);
    @(posedge clk);
    #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    wb_access(1'b1, adr, dat, dummy);
  endtask

  // Expected beats: the buffer is cut into bursts of min(burst, words left).
  task automatic start_xfer(input logic [31:0] start, input int bytes, input int burst,
                            input logic [31:0] enable);
    int words, i, len;
    words = bytes / 4;
    i = 0;
    while (i < words) begin
      len = (words - i < burst) ? words - i : burst;
      for (int j = 0; j < len; j++) begin
        exp_adr_q.push_back(start + 32'(4 * (i + j)));
        exp_cti_q.push_back((j == len - 1) ? 3'b111 : 3'b010);
        exp_q.push_back(mem[((start >> 2) + 32'(i + j)) % 1024]);
      end
      i += len;
    end
    wb_write(32'h4, start);
    wb_write(32'h8, 32'(bytes));
    wb_write(32'hC, 32'(burst));
    wb_write(32'h0, enable);
  endtask

  task automatic wait_irq(input int bound, input string tag);
    int n;
    n = 0;
    while (!stream_m_irq_o && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, stream_m_irq_o, 1'b1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_adr_q.delete();
    exp_cti_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, bytes, burst;
    logic [31:0] rd, start;
    int pcts [3] = '{8, 50, 100};

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cyc", wbm_cyc_o, 1'b0);
    check("rst_stb", wbm_stb_o, 1'b0);
    check("rst_cti", {29'd0, wbm_cti_o}, 32'd0);
    check("rst_valid", stream_m_valid_o, 1'b0);
    check("rst_irq", stream_m_irq_o, 1'b0);
    check("rst_wbs_ack", wbs_ack_o, 1'b0);
    check("const_sel", {28'd0, wbm_sel_o}, 32'hf);
    check("const_we", wbm_we_o, 1'b0);
    rst = 1'b0;

    // Single burst of 8 words from 0x40
    a0 = bursts;
    start_xfer(32'h40, 32, 8, 32'h1);
    wait_irq(500, "t1_irq");
    check("t1_bursts", 32'(bursts - a0), 32'd1);
    check("t1_left_words", 32'(exp_q.size()), 32'd0);
    check("t1_left_beats", 32'(exp_adr_q.size()), 32'd0);

    // Clearing the interrupt
    wb_write(32'h0, 32'h2);
    check("irq_clear", stream_m_irq_o, 1'b0);

    // Zero-length buffer completes immediately with no bus traffic
    a0 = acks;
    start_xfer(32'h80, 0, 4, 32'h1);
    wait_irq(50, "zero_len_irq");
    check("zero_len_acks", 32'(acks - a0), 32'd0);
    wb_write(32'h0, 32'h2);

    // Back-pressure: FIFO fills, fetching stalls, start while busy is ignored
    ready_pct = 0;
    a0 = acks;
    start_xfer(32'h100, 128, 2, 32'h1);
    repeat (200) @(negedge clk);
    check("stall_acks", 32'(acks - a0), 32'd32);
    check("stall_valid", stream_m_valid_o, 1'b1);
    check("stall_cyc", wbm_cyc_o, 1'b0);
    check("stall_irq", stream_m_irq_o, 1'b0);
    wb_write(32'h0, 32'h1);
    repeat (20) @(negedge clk);
    check("busy_start_ignored", 32'(acks - a0), 32'd32);
    ready_pct = 100;
    wait_irq(500, "stall_irq_done");
    check("stall_total_acks", 32'(acks - a0), 32'd32);
    check("stall_left_words", 32'(exp_q.size()), 32'd0);

    // Start and clear in one write: old irq cleared, new transfer runs
    start_xfer(32'h300, 16, 4, 32'h3);
    check("start_clear_irq", stream_m_irq_o, 1'b0);
    wait_irq(500, "start_clear_done");
    check("start_clear_left", 32'(exp_q.size()), 32'd0);
    wb_write(32'h0, 32'h2);

    // Random memory latency, retries and consumer back-pressure
    max_delay = 5;
    rty_pct = 10;
    for (int it = 0; it < 4; it++) begin
      ready_pct = pcts[$urandom_range(2)];
      start = 32'($urandom_range(255)) * 4;
      bytes = int'($urandom_range(64, 1)) * 4;
      burst = int'($urandom_range(32, 1));
      a0 = acks;
      start_xfer(start, bytes, burst, 32'h1);
      wait_irq(20000, "rand_irq");
      check("rand_acks", 32'(acks - a0), 32'(bytes / 4));
      check("rand_left_words", 32'(exp_q.size()), 32'd0);
      wb_write(32'h0, 32'h2);
    end
    max_delay = 0;
    rty_pct = 0;
    ready_pct = 100;

    // Bus error on beat 3 of 8 aborts the transfer
    a0 = acks;
    err_at = acks + 2;
    start_xfer(32'h200, 32, 8, 32'h1);
    wait_irq(200, "err_irq");
    repeat (5) @(negedge clk);
    err_at = -1;
    check("err_acks", 32'(acks - a0), 32'd2);
    check("err_cyc", wbm_cyc_o, 1'b0);
    check("err_words_left", 32'(exp_q.size()), 32'd6);
    clear_model();
    wb_write(32'h0, 32'h2);
    start_xfer(32'h80, 16, 4, 32'h1);
    wait_irq(500, "after_err_irq");
    check("after_err_left", 32'(exp_q.size()), 32'd0);

    // Register readback (ENABLE reads {irq, busy})
    wb_access(1'b0, 32'h0, 32'h0, rd);
`ifdef WB_STREAM_WRITER_READBACK_EN
    check("rb_enable", rd, 32'h2);
`else
    check("rb_enable", rd, 32'h0);
`endif
    wb_write(32'h0, 32'h2);
    wb_write(32'h4, 32'h1F0);
    wb_access(1'b0, 32'h4, 32'h0, rd);
`ifdef WB_STREAM_WRITER_READBACK_EN
    check("rb_start_addr", rd, 32'h1F0);
`else
    check("rb_start_addr", rd, 32'h0);
`endif

    // Reset in the middle of a burst
    max_delay = 3;
    ready_pct = 0;
    start_xfer(32'h20, 128, 16, 32'h1);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cyc", wbm_cyc_o, 1'b0);
    check("midrst_valid", stream_m_valid_o, 1'b0);
    check("midrst_irq", stream_m_irq_o, 1'b0);
    rst = 1'b0;
    clear_model();
    max_delay = 0;
    ready_pct = 100;
    wb_access(1'b0, 32'h4, 32'h0, rd);
    check("midrst_reg_cleared", rd, 32'h0);
    start_xfer(32'h40, 32, 8, 32'h1);
    wait_irq(500, "post_rst_irq");
    check("post_rst_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
